// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: channel ids and
// the default datapath widths used by the ALU and register file.
package rf_write_arbiter_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

endpackage

// File: rtl/rf_write_arbiter_mux.sv
// Team 2:1 data mux: y follows a when sel is 0, b when sel is 1.
module mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select between the two inputs.
  always_comb begin
    y = sel ? b : a;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// two producers. Grants are combinational; the winning write is registered
// onto the write port one cycle later. A saturating counter tracks how often
// both producers competed for an available port.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = rf_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W = rf_write_arbiter_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              rf_ready,
  output logic              gnt0,
  output logic              gnt1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              sel_ch,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              sel_ch_q, sel_ch_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              gnt_any;
  logic              gnt_ch;
  logic              contended;
  logic [DATA_W-1:0] mux_data;

  // Pick the winning channel: a lone requester wins, a tie goes to the
  // channel that did not win last time. Nothing is granted during reset.
  always_comb begin
    contended = req0 & req1 & rf_ready;
    gnt_any   = ~rst & rf_ready & (req0 | req1);
    if (req0 & req1) begin
      gnt_ch = ~last_gnt_q;
    end else if (req1) begin
      gnt_ch = CH1;
    end else begin
      gnt_ch = CH0;
    end
    gnt0 = gnt_any & (gnt_ch == CH0);
    gnt1 = gnt_any & (gnt_ch == CH1);
  end

  mux #(.WIDTH(DATA_W)) u_data_mux (
    .a  (data0),
    .b  (data1),
    .sel(gnt_ch),
    .y  (mux_data)
  );

  // Next-state for the write port and arbitration history; with no grant the
  // write enable drops while address, data and channel hold.
  always_comb begin
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    sel_ch_d       = sel_ch_q;
    last_gnt_d     = last_gnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (gnt_any) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = (gnt_ch == CH1) ? addr1 : addr0;
      wr_data_d  = mux_data;
      sel_ch_d   = gnt_ch;
      last_gnt_d = gnt_ch;
    end
    if (contended && (conflict_cnt_q != {CNT_W{1'b1}})) begin
      conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; reset drops any in-flight write and biases the first
  // contested grant toward channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      sel_ch_q       <= CH0;
      last_gnt_q     <= CH1;
      conflict_cnt_q <= '0;
    end else begin
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      sel_ch_q       <= sel_ch_d;
      last_gnt_q     <= last_gnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign sel_ch       = sel_ch_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter. A second instance with a 4-bit
// counter shares the same stimulus so counter saturation can be observed.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1, rf_ready;
  logic [4:0]  addr0, addr1;
  logic [31:0] data0, data1;

  logic        gnt0, gnt1, wr_en, sel_ch;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [15:0] conflict_cnt;

  logic        s_gnt0, s_gnt1, s_wr_en, s_sel_ch;
  logic [4:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [3:0]  s_conflict_cnt;

  int errors = 0;
  int checks = 0;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .rf_ready(rf_ready),
    .gnt0(gnt0), .gnt1(gnt1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sel_ch(sel_ch), .conflict_cnt(conflict_cnt)
  );

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .rf_ready(rf_ready),
    .gnt0(s_gnt0), .gnt1(s_gnt1),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .sel_ch(s_sel_ch), .conflict_cnt(s_conflict_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one full set of requester inputs.
  task automatic applyStimulus(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic rdy);
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
    rf_ready = rdy;
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; each step hand-computes what the arbiter must show.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd77, 1'b1);
    checkOutput("rst_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("rst_gnt1", {31'd0, gnt1}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_sel_ch", {31'd0, sel_ch}, 32'd0);
    checkOutput("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    rst = 1'b0;
    #1;

    // Single requester on channel 0.
    applyStimulus(1'b1, 5'd3, 32'd102, 1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("single_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("single_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("single_wr_en", {31'd0, wr_en}, 32'd1);
    checkOutput("single_wr_addr", {27'd0, wr_addr}, 32'd3);
    checkOutput("single_wr_data", wr_data, 32'd102);
    checkOutput("single_sel_ch", {31'd0, sel_ch}, 32'd0);
    tick();
    checkOutput("idle_wr_en", {31'd0, wr_en}, 32'd0);

    // Single requester on channel 1 leaves channel 1 as last winner.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD, 1'b1);
    checkOutput("single1_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    checkOutput("single1_wr_addr", {27'd0, wr_addr}, 32'd7);
    checkOutput("single1_wr_data", wr_data, 32'hDEAD);
    checkOutput("single1_sel_ch", {31'd0, sel_ch}, 32'd1);

    // Contention: both held four cycles, grants alternate starting at 0.
    applyStimulus(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd77, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cont_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput("cont_gnt1", {31'd0, gnt1}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      checkOutput("cont_wr_data", wr_data, (i % 2 == 0) ? 32'd53 : 32'd77);
      checkOutput("cont_wr_addr", {27'd0, wr_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      checkOutput("cont_wr_en", {31'd0, wr_en}, 32'd1);
    end
    checkOutput("cont_cnt", {16'd0, conflict_cnt}, 32'd4);

    // Stall: port not ready for three cycles, nothing moves but wr_en.
    applyStimulus(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_gnt0", {31'd0, gnt0}, 32'd0);
      checkOutput("stall_gnt1", {31'd0, gnt1}, 32'd0);
      tick();
      checkOutput("stall_wr_en", {31'd0, wr_en}, 32'd0);
      checkOutput("stall_wr_addr", {27'd0, wr_addr}, 32'd2);
      checkOutput("stall_wr_data", wr_data, 32'd77);
      checkOutput("stall_cnt", {16'd0, conflict_cnt}, 32'd4);
    end
    applyStimulus(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd77, 1'b1);
    checkOutput("resume_gnt0", {31'd0, gnt0}, 32'd1);
    tick();
    checkOutput("resume_wr_data", wr_data, 32'd53);
    checkOutput("resume_cnt", {16'd0, conflict_cnt}, 32'd5);
    checkOutput("resume2_gnt1", {31'd0, gnt1}, 32'd1);
    tick();
    checkOutput("resume2_wr_data", wr_data, 32'd77);
    checkOutput("resume2_cnt", {16'd0, conflict_cnt}, 32'd6);

    // Withdrawal: req1 raised while stalled, then dropped.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd9, 1'b0);
    checkOutput("wd_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    checkOutput("wd_wr_en", {31'd0, wr_en}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 32'd9, 1'b1);
    checkOutput("wd2_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    checkOutput("wd2_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("wd2_wr_data", wr_data, 32'd77);

    // Reset mid-operation drops the pending write immediately.
    applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1);
    tick();
    checkOutput("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    applyStimulus(1'b1, 5'd1, 32'd53, 1'b1, 5'd2, 32'd77, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    checkOutput("midrst_wr_addr", {27'd0, wr_addr}, 32'd0);
    checkOutput("midrst_wr_data", wr_data, 32'd0);
    checkOutput("midrst_cnt", {16'd0, conflict_cnt}, 32'd0);
    checkOutput("midrst_gnt0", {31'd0, gnt0}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("postrst_gnt0", {31'd0, gnt0}, 32'd1);
    checkOutput("postrst_gnt1", {31'd0, gnt1}, 32'd0);
    tick();
    checkOutput("postrst_wr_data", wr_data, 32'd53);
    checkOutput("postrst_sel_ch", {31'd0, sel_ch}, 32'd0);

    // Saturation: twenty more contested cycles, 21 in total since reset.
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_main_cnt", {16'd0, conflict_cnt}, 32'd21);
    checkOutput("sat_small_cnt", {28'd0, s_conflict_cnt}, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
